// File: rtl/job_controller_pkg.sv
// Shared CAPI job-control definitions: command codes, job interface payloads
// and the job controller state type.
package job_controller_pkg;

  localparam int unsigned CMD_W  = 8;
  localparam int unsigned ADDR_W = 64;

  // CAPI job command codes
  localparam logic [CMD_W-1:0] CMD_RESET = 8'h80;
  localparam logic [CMD_W-1:0] CMD_START = 8'h90;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESETTING = 2'd1,
    RUNNING   = 2'd2,
    FINISH    = 2'd3
  } JobState;

  typedef struct packed {
    logic              valid;
    logic [CMD_W-1:0]  command;
    logic [ADDR_W-1:0] address;
  } JobInterfaceInput;

  typedef struct packed {
    logic running;
    logic done;
    logic cack;
    logic error;
    logic yield;
  } JobInterfaceOutput;

endpackage

// File: rtl/job_controller_delay_line.sv
// Fixed-depth shift register that delays a small status word.
// Ports:
//   clock    - sole clock
//   reset_n  - synchronous active-low clear of every stage
//   flush    - discard all in-flight words; data_in is still loaded
//   data_in  - word entering stage 0
//   data_out - word leaving the last stage (DEPTH cycles after entry)
module delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift; a flush keeps only the word arriving this cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= data_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= flush ? '0 : stage[i-1];
      end
    end
  end

  assign data_out = stage[DEPTH-1];

endmodule

// File: rtl/job_controller.sv
// CAPI job controller: accepts START/RESET commands, launches NUM_ENGINES work
// engines, tracks their completion, optional run-time limit and reports
// job done/error after DONE_LATENCY cycles.
// Ports:
//   clock, reset_n - clock and synchronous active-low reset
//   job_in         - CAPI job control (valid, command, address)
//   job_out        - CAPI job status (running, done, error; yield/cack tied 0)
//   engine_start   - one-cycle start pulse per engine
//   engine_done    - per-engine completion pulse
//   engine_error   - per-engine error, qualified by engine_done
//   wed_address    - work element descriptor address captured at START
//   cycle_count    - RUNNING cycles of the current/last job (saturating)
module job_controller
  import job_controller_pkg::*;
#(
  parameter int unsigned NUM_ENGINES    = 1,
  parameter int unsigned DONE_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  JobInterfaceInput       job_in,
  output JobInterfaceOutput      job_out,
  output logic [NUM_ENGINES-1:0] engine_start,
  input  logic [NUM_ENGINES-1:0] engine_done,
  input  logic [NUM_ENGINES-1:0] engine_error,
  output logic [ADDR_W-1:0]      wed_address,
  output logic [31:0]            cycle_count
);

  localparam int unsigned COUNT_W  = 32;
  localparam int unsigned STATUS_W = 2;  // {error, done}
  localparam logic [NUM_ENGINES-1:0] ALL_DONE = '1;

  JobState                state;
  logic                   running_q;
  logic [NUM_ENGINES-1:0] done_mask;
  logic                   error_flag;

  logic                   cmd_reset_c;
  logic                   cmd_start_c;
  logic                   err_hit_c;
  logic                   timeout_c;
  logic                   finish_c;
  logic [NUM_ENGINES-1:0] mask_next_c;
  logic [COUNT_W-1:0]     count_inc_c;
  logic [STATUS_W-1:0]    dl_in_c;
  logic [STATUS_W-1:0]    dl_out;

  // Command decode, completion detection and the status word entering the delay
  always_comb begin
    cmd_reset_c = job_in.valid && (job_in.command == CMD_RESET);
    cmd_start_c = job_in.valid && (job_in.command == CMD_START);
    mask_next_c = done_mask | engine_done;
    err_hit_c   = |(engine_done & engine_error);
    count_inc_c = (cycle_count == '1) ? cycle_count : cycle_count + COUNT_W'(1);
    timeout_c   = (TIMEOUT_CYCLES != 0) && (count_inc_c == COUNT_W'(TIMEOUT_CYCLES));
    finish_c    = (mask_next_c == ALL_DONE) || timeout_c;
    dl_in_c     = '0;
    if (cmd_reset_c) begin
      dl_in_c = 2'b01;  // reset-done never carries error
    end else if (state == RUNNING && finish_c) begin
      dl_in_c = {error_flag | err_hit_c | timeout_c, 1'b1};
    end
  end

  // RESET flushes any pending job-done so only the reset-done emerges
  delay_line #(
    .DEPTH (DONE_LATENCY),
    .WIDTH (STATUS_W)
  ) u_done_delay (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (cmd_reset_c),
    .data_in  (dl_in_c),
    .data_out (dl_out)
  );

  // Job sequencing; RESET command overrides everything including engine events
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      running_q    <= 1'b0;
      done_mask    <= '0;
      error_flag   <= 1'b0;
      engine_start <= '0;
      wed_address  <= '0;
      cycle_count  <= '0;
    end else begin
      engine_start <= '0;
      if (cmd_reset_c) begin
        state       <= RESETTING;
        running_q   <= 1'b0;
        done_mask   <= '0;
        error_flag  <= 1'b0;
        cycle_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_start_c) begin
              state        <= RUNNING;
              running_q    <= 1'b1;
              wed_address  <= job_in.address;
              engine_start <= ALL_DONE;
              done_mask    <= '0;
              error_flag   <= 1'b0;
              cycle_count  <= '0;
            end
          end
          RUNNING: begin
            cycle_count <= count_inc_c;
            done_mask   <= mask_next_c;
            error_flag  <= error_flag | err_hit_c | timeout_c;
            if (finish_c) state <= FINISH;
          end
          RESETTING, FINISH: begin
            // Leave once the delayed done pulse is on the output
            if (dl_out[0]) begin
              state     <= IDLE;
              running_q <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    job_out         = '0;
    job_out.running = running_q;
    job_out.done    = dl_out[0];
    job_out.error   = dl_out[1];
  end

endmodule

// File: tb/tb_job_controller.sv
module tb_job_controller;
  import job_controller_pkg::*;

  localparam int NE = 4;
  localparam int DL = 3;
  localparam int TO = 50;

  logic              clock;
  logic              reset_n;
  JobInterfaceInput  job_in;
  JobInterfaceOutput job_out;
  logic [NE-1:0]     engine_start;
  logic [NE-1:0]     engine_done;
  logic [NE-1:0]     engine_error;
  logic [63:0]       wed_address;
  logic [31:0]       cycle_count;

  int checks   = 0;
  int failures = 0;

  job_controller #(
    .NUM_ENGINES    (NE),
    .DONE_LATENCY   (DL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .job_in       (job_in),
    .job_out      (job_out),
    .engine_start (engine_start),
    .engine_done  (engine_done),
    .engine_error (engine_error),
    .wed_address  (wed_address),
    .cycle_count  (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: job phase, countdown to the pending done pulse, engines seen
  typedef enum {M_IDLE, M_RUN, M_WAIT_RESET, M_WAIT_JOB} mphase_t;
  mphase_t         m_phase = M_IDLE;
  int              m_left = 0;
  bit              m_seen [NE];
  bit              m_job_err = 0;
  bit              m_wait_err = 0;
  bit              m_start = 0;
  logic [63:0]     m_wed = '0;
  longint unsigned m_count = 0;

  function automatic bit m_waiting();
    return (m_phase == M_WAIT_RESET) || (m_phase == M_WAIT_JOB);
  endfunction

  task automatic model_edge(input logic rn, input logic v, input logic [7:0] c,
                            input logic [63:0] addr, input logic [NE-1:0] ed,
                            input logic [NE-1:0] ee);
    bit done_now, all_in, finished;
    done_now = m_waiting() && (m_left == 1);
    m_start = 0;
    if (!rn) begin
      m_phase = M_IDLE; m_left = 0; m_wed = '0; m_count = 0;
      m_job_err = 0; m_wait_err = 0;
      for (int i = 0; i < NE; i++) m_seen[i] = 0;
    end else if (v && c == CMD_RESET) begin
      m_phase = M_WAIT_RESET; m_left = DL; m_wait_err = 0;
      m_job_err = 0; m_count = 0;
      for (int i = 0; i < NE; i++) m_seen[i] = 0;
    end else begin
      case (m_phase)
        M_IDLE: begin
          if (v && c == CMD_START) begin
            m_wed = addr; m_start = 1; m_count = 0; m_job_err = 0;
            for (int i = 0; i < NE; i++) m_seen[i] = 0;
            m_phase = M_RUN;
          end
        end
        M_RUN: begin
          if (m_count < 64'hFFFF_FFFF) m_count++;
          for (int i = 0; i < NE; i++) begin
            if (ed[i]) begin
              m_seen[i] = 1;
              if (ee[i]) m_job_err = 1;
            end
          end
          all_in = 1;
          for (int i = 0; i < NE; i++) if (!m_seen[i]) all_in = 0;
          finished = all_in;
          if (TO != 0 && m_count == longint'(TO)) begin
            m_job_err = 1;
            finished = 1;
          end
          if (finished) begin
            m_phase = M_WAIT_JOB; m_left = DL; m_wait_err = m_job_err;
          end
        end
        default: begin
          if (done_now) m_phase = M_IDLE;
          else m_left--;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    bit exp_done;
    exp_done = m_waiting() && (m_left == 1);
    check("running", 64'(job_out.running), 64'(m_phase == M_RUN || m_phase == M_WAIT_JOB));
    check("done", 64'(job_out.done), 64'(exp_done));
    check("error", 64'(job_out.error), 64'(exp_done && m_phase == M_WAIT_JOB && m_wait_err));
    check("yield", 64'(job_out.yield), 64'(0));
    check("cack", 64'(job_out.cack), 64'(0));
    check("engine_start", 64'(engine_start), m_start ? 64'((1 << NE) - 1) : 64'(0));
    check("wed_address", wed_address, m_wed);
    check("cycle_count", 64'(cycle_count), m_count);
  endtask

  // One clock: drive on the falling edge, model on the rising edge, compare next falling edge
  task automatic step(input logic rn, input logic v, input logic [7:0] c,
                      input logic [63:0] addr, input logic [NE-1:0] ed,
                      input logic [NE-1:0] ee);
    reset_n          = rn;
    job_in.valid     = v;
    job_in.command   = c;
    job_in.address   = addr;
    engine_done      = ed;
    engine_error     = ee;
    @(posedge clock);
    model_edge(rn, v, c, addr, ed, ee);
    @(negedge clock);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 8'h00, 64'h0, '0, '0);
  endtask

  task automatic send(input logic [7:0] c, input logic [63:0] addr);
    step(1'b1, 1'b1, c, addr, '0, '0);
  endtask

  // Idle for a bounded number of cycles, counting done pulses; first_at is in
  // cycles after the cycle that launched the event
  task automatic collect(input int budget, output int pulses, output int first_at,
                         output logic err_seen);
    pulses = 0; first_at = -1; err_seen = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      idle(1);
      if (job_out.done) begin
        pulses++;
        if (first_at < 0) first_at = k + 1;
        if (job_out.error) err_seen = 1'b1;
      end
    end
  endtask

  initial begin
    int   pulses, first_at;
    logic err_seen;

    // Reset held two cycles, then quiet
    step(1'b0, 1'b0, 8'h00, 64'h0, '0, '0);
    step(1'b0, 1'b0, 8'h00, 64'h0, '0, '0);
    check("reset_running", 64'(job_out.running), 64'(0));
    collect(20, pulses, first_at, err_seen);
    check("reset_no_done", 64'(pulses), 64'(0));

    // Unknown command ignored
    send(8'h20, 64'hDEAD);
    check("ignored_cmd_running", 64'(job_out.running), 64'(0));

    // RESET command: single done DL cycles later, never running
    send(CMD_RESET, 64'h0);
    check("reset_cmd_running", 64'(job_out.running), 64'(0));
    collect(8, pulses, first_at, err_seen);
    check("reset_cmd_pulses", 64'(pulses), 64'(1));
    check("reset_cmd_latency", 64'(first_at), 64'(DL));

    // Four engines, out-of-order and duplicate completions
    send(CMD_START, 64'h1000);
    check("start_pulse", 64'(engine_start), 64'hF);
    check("start_wed", wed_address, 64'h1000);
    idle(1);
    check("start_pulse_once", 64'(engine_start), 64'h0);
    step(1'b1, 1'b0, 8'h00, 64'h0, 4'b0100, '0);
    step(1'b1, 1'b0, 8'h00, 64'h0, 4'b0001, '0);
    step(1'b1, 1'b0, 8'h00, 64'h0, 4'b0001, '0);
    idle(2);
    step(1'b1, 1'b0, 8'h00, 64'h0, 4'b1000, '0);
    check("partial_running", 64'(job_out.running), 64'(1));
    step(1'b1, 1'b0, 8'h00, 64'h0, 4'b0010, '0);
    collect(8, pulses, first_at, err_seen);
    check("job4_pulses", 64'(pulses), 64'(1));
    check("job4_latency", 64'(first_at), 64'(DL));
    check("job4_error", 64'(err_seen), 64'(0));

    // Engine error reported, then a clean job clears it
    send(CMD_START, 64'h2000);
    step(1'b1, 1'b0, 8'h00, 64'h0, 4'b1101, '0);
    step(1'b1, 1'b0, 8'h00, 64'h0, 4'b0010, 4'b0010);
    collect(8, pulses, first_at, err_seen);
    check("err_job_pulses", 64'(pulses), 64'(1));
    check("err_job_error", 64'(err_seen), 64'(1));
    send(CMD_START, 64'h3000);
    step(1'b1, 1'b0, 8'h00, 64'h0, 4'b1111, '0);
    collect(8, pulses, first_at, err_seen);
    check("clean_job_error", 64'(err_seen), 64'(0));

    // Timeout with no engine completions
    send(CMD_START, 64'h4000);
    collect(60, pulses, first_at, err_seen);
    check("timeout_count", 64'(cycle_count), 64'(TO));
    check("timeout_pulses", 64'(pulses), 64'(1));
    check("timeout_error", 64'(err_seen), 64'(1));
    check("timeout_running", 64'(job_out.running), 64'(0));

    // RESET wins over simultaneous engine completion
    send(CMD_START, 64'h5000);
    idle(4);
    step(1'b1, 1'b1, CMD_RESET, 64'h0, 4'b1111, 4'b1111);
    collect(10, pulses, first_at, err_seen);
    check("reset_race_pulses", 64'(pulses), 64'(1));
    check("reset_race_latency", 64'(first_at), 64'(DL));
    check("reset_race_error", 64'(err_seen), 64'(0));
    send(CMD_START, 64'h6000);
    check("restart_pulse", 64'(engine_start), 64'hF);
    check("restart_wed", wed_address, 64'h6000);
    step(1'b1, 1'b0, 8'h00, 64'h0, 4'b1111, '0);
    idle(6);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic          rn, v;
      logic [7:0]    c;
      logic [NE-1:0] ed, ee;
      int            sel;
      rn  = ($urandom_range(0, 299) != 0);
      v   = ($urandom_range(0, 7) == 0);
      sel = int'($urandom_range(0, 3));
      c   = (sel < 2) ? CMD_START : (sel == 2) ? CMD_RESET : 8'($urandom);
      ed  = '0;
      ee  = '0;
      for (int i = 0; i < NE; i++) begin
        ed[i] = ($urandom_range(0, 9) == 0);
        ee[i] = ($urandom_range(0, 5) == 0);
      end
      step(rn, v, c, {32'($urandom), 32'($urandom)}, ed, ee);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/job_controller.md
JOB_CONTROLLER -- requirements
Module: job_controller

Interface
REQ-001 Parameter NUM_ENGINES, default 1, number of work engines started and tracked per job (1..16).
REQ-002 Parameter DONE_LATENCY, default 1, cycles from internal done/reset event to job_out.done pulse (1..8).
REQ-003 Parameter TIMEOUT_CYCLES, default 0, run-time limit in clock cycles; 0 disables timeout.
REQ-004 clock  input  1  sole clock; all logic on posedge clock.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 job_in  input  JobInterfaceInput  CAPI job control (valid, command, address used).
REQ-007 job_out  output  JobInterfaceOutput  CAPI job status (running, done, error, yield, cack driven).
REQ-008 engine_start  output  NUM_ENGINES  one-cycle start pulse per engine.
REQ-009 engine_done  input  NUM_ENGINES  per-engine completion pulse.
REQ-010 engine_error  input  NUM_ENGINES  per-engine error pulse, sampled with engine_done.
REQ-011 wed_address  output  64  work element descriptor address latched at START.
REQ-012 cycle_count  output  32  cycles spent in RUNNING for the current/last job.

Function
REQ-013 States: IDLE, RESETTING, RUNNING, FINISH; encoding is free.
REQ-014 job_out.yield and job_out.cack are tied 0.
REQ-015 job_in.valid with command RESET in any state: go to RESETTING, clear engine tracking, cycle_count, error; exactly one job_out.done pulse DONE_LATENCY cycles later; then IDLE.
REQ-016 job_in.valid with command START in IDLE: latch job_in.address into wed_address, pulse all engine_start bits for exactly one cycle on the next cycle, enter RUNNING.
REQ-017 START received outside IDLE is ignored; no state, output or counter change.
REQ-018 Commands other than RESET and START are ignored in all states.
REQ-019 job_out.running is 1 exactly while in RUNNING or FINISH and 0 otherwise.
REQ-020 In RUNNING, a per-engine sticky done mask sets on engine_done[i]; duplicate pulses have no further effect.
REQ-021 When all NUM_ENGINES mask bits are set (including bits set that same cycle), enter FINISH.
REQ-022 Any engine_error[i] with engine_done[i] in RUNNING sets a sticky error flag.
REQ-023 cycle_count increments by 1 each RUNNING cycle, saturates at 2^32-1, holds in other states, clears on START and RESET.
REQ-024 With TIMEOUT_CYCLES > 0, when cycle_count reaches TIMEOUT_CYCLES in RUNNING: set error flag, enter FINISH regardless of mask.
REQ-025 FINISH: job_out.done pulses one cycle DONE_LATENCY cycles after FINISH entry; job_out.error is asserted in that same cycle if error flag set; then IDLE.
REQ-026 job_out.error is 0 in all cycles except the done pulse of a job ending with error set.
REQ-027 RESET arriving during RUNNING or during an outstanding FINISH done delay cancels the pending job done; only the reset-done pulse is produced, error not asserted.
REQ-028 RESET simultaneous with engine_done: RESET wins; engine events in that cycle are discarded.
REQ-029 engine_done/engine_error outside RUNNING are ignored.

Reset
REQ-030 reset_n low at a clock edge: state IDLE; job_out.done, job_out.error, job_out.running, engine_start 0; wed_address, cycle_count, mask, error flag, delay line 0.
REQ-031 reset_n low drops any in-flight done pulse; no job_out.done is produced by reset_n itself.

Structure
REQ-032 State enumeration and the START/RESET command codes come from the shared CAPI package; local state type added there as JobState.
REQ-033 The DONE_LATENCY delay uses one sub-module, delay_line, parametrised by depth, with synchronous active-low clear and a flush input driven on RESET.

Verification
REQ-034 reset_n low 2 cycles, then high -> all outputs 0, running 0, no done pulse within 20 cycles.
REQ-035 DONE_LATENCY=3, RESET command at cycle 10 -> job_out.done high only at cycle 13, running 0 throughout.
REQ-036 NUM_ENGINES=4, START address 0x1000 -> engine_start=4'hF one cycle, wed_address=0x1000; done pulses on engines 2,0,0,3,1 -> FINISH entered on the cycle engine 1 pulses, single done, error 0.
REQ-037 NUM_ENGINES=2, engine 1 done with error -> done pulse with job_out.error 1; next START then clean completion -> error 0.
REQ-038 TIMEOUT_CYCLES=50, START, no engine_done -> cycle_count 50, done with error 1, running falls after done.
REQ-039 START, RESET 5 cycles later while engine_done arrives same cycle -> one reset-done pulse only, no job done, second START accepted from IDLE.
